mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sits between the I/D cache memory_system instances and single-ported main memory. Grants the
//  bus to one cache miss fill at a time, ICACHE priority, grant locked for the whole fill.
//  Buffers D-side write-through stores in a small FIFO, drained to memory on idle cycles.
//  Keeps read-after-write ordering: D-side fills wait until the buffer is empty.
// PARAMETERS
//  ADDR_W      16  address width (byte address)
//  DATA_W      16  word width
//  WBUF_DEPTH  4   write-buffer entries; power of two, >=2
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst_n         in   1       synchronous, active-low reset
//  icache_req    in   1       ICACHE fsm_busy (miss fill pending)
//  icache_addr   in   ADDR_W  ICACHE off_chip_memory_address
//  dcache_req    in   1       DCACHE fsm_busy
//  dcache_addr   in   ADDR_W  DCACHE off_chip_memory_address
//  st_valid      in   1       write-through store offered (DCACHE hit & MemWrite & MemEnable)
//  st_addr       in   ADDR_W  store address
//  st_data       in   DATA_W  store data
//  st_stall      out  1       buffer full; store not taken, pipeline must hold
//  icache_proceed out 1       ICACHE owns memory bus
//  dcache_proceed out 1       DCACHE owns memory bus
//  mem_en        out  1       main memory enable
//  mem_wr        out  1       main memory write
//  mem_addr      out  ADDR_W  main memory address
//  mem_wdata     out  DATA_W  main memory write data
//  wbuf_empty    out  1       no buffered stores
//  perf_i_fills  out  16      ICACHE grant count (ARB_PERF_CNT_EN)
//  perf_d_fills  out  16      DCACHE grant count (ARB_PERF_CNT_EN)
//  perf_stalls   out  16      cycles with st_stall high (ARB_PERF_CNT_EN)
// BEHAVIOUR
//  - States: IDLE, GRANT_I, GRANT_D, WRITE (arb_state_t). Reset -> IDLE, buffer empty, every output 0
//    except wbuf_empty=1. Reset mid-fill or with buffered stores: state IDLE, buffer flushed (stores lost).
//  - IDLE next-state, priority order:
//    1 buffer full                     -> WRITE
//    2 icache_req                      -> GRANT_I
//    3 dcache_req & buffer empty       -> GRANT_D
//    4 buffer not empty                -> WRITE
//    5 else stay IDLE
//  - GRANT_I holds while icache_req=1; icache_req=0 -> IDLE. GRANT_D likewise on dcache_req. No pre-emption.
//  - WRITE lasts exactly 1 cycle: pops head entry, then -> IDLE.
//  - Latency: req first high in cycle n -> proceed high in cycle n+1. Release: req low in cycle m ->
//    proceed low in cycle m+1. At least one IDLE cycle between any two grants.
//  - Outputs decode registered state only. icache_proceed=(GRANT_I), dcache_proceed=(GRANT_D),
//    mem_en=(state!=IDLE), mem_wr=(WRITE). mem_addr = icache_addr | dcache_addr | head.addr per state,
//    else 0. mem_wdata = head.data in WRITE, else 0.
//  - Push when st_valid & ~full. st_stall = st_valid & full, combinational. A push blocked by full stays
//    blocked even if the same cycle pops. Push+pop same cycle when not full: count unchanged.
//  - Pointers are log2(WBUF_DEPTH) bits and wrap modulo WBUF_DEPTH. count is log2(WBUF_DEPTH)+1 bits.
//    FIFO order is preserved across wrap.
//  - dcache_req with non-empty buffer: every entry drains before GRANT_D, so no fill reads stale data.
// CONFIGURATION
//  - `ARB_PERF_CNT_EN defined: three 16-bit counters. Counters clear on reset and wrap at 16'hFFFF->0.
//    perf_i_fills/perf_d_fills increment on each IDLE->GRANT_I/GRANT_D transition.
//    perf_stalls increments on each cycle st_stall=1.
//  - Not defined: no counter flops; the perf_* ports are tied to 0.
// STRUCTURE
//  - mem_arb_pkg: arb_state_t enum; ADDR_W/DATA_W defaults; wbuf_entry_t struct {addr, data}.
//  - Sub-module wbuf_fifo: parameterised FIFO with push/pop/full/empty/head. Arbiter FSM plus output
//    decode stay in mem_arbiter.
// TESTING
//  1 Reset, no reqs -> all outputs 0, wbuf_empty=1. icache_req at cycle 5 -> icache_proceed=1 from cycle 6,
//    mem_addr=icache_addr.
//  2 icache_req & dcache_req same cycle, buffer empty -> GRANT_I first. icache_req drops -> 1 IDLE cycle,
//    then dcache_proceed=1.
//  3 Stores A=0x0010/0x1111, B=0x0020/0x2222, no reqs -> two WRITE cycles in order, mem_wr=1,
//    mem_addr 0x0010 then 0x0020.
//  4 Buffer holds 2 stores, then dcache_req=1 -> both stores written before dcache_proceed=1.
//  5 Fill 4 entries during long GRANT_I, then 5th st_valid -> st_stall=1, entry not taken.
//    Fill ends -> WRITE beats IDLE arbitration; pointer wrap checked after 6 more pushes.
//  6 rst_n=0 mid-GRANT_D with 3 buffered -> next cycle IDLE, wbuf_empty=1, perf_* = 0
//    (with ARB_PERF_CNT_EN).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D cache to main-memory arbiter.
// Widths, FSM state encoding and write-buffer entry layout.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WBUF_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    WRITE
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side bus of mem_arbiter.
// slave = arbiter view, master = the surrounding system.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic              icache_req;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_req;
  logic [ADDR_W-1:0] dcache_addr;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_stall;
  logic              icache_proceed;
  logic              dcache_proceed;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wbuf_empty;
  logic [15:0]       perf_i_fills;
  logic [15:0]       perf_d_fills;
  logic [15:0]       perf_stalls;

  modport slave (
    input  icache_req, icache_addr,
    input  dcache_req, dcache_addr,
    input  st_valid, st_addr, st_data,
    output st_stall,
    output icache_proceed, dcache_proceed,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output wbuf_empty,
    output perf_i_fills, perf_d_fills, perf_stalls
  );

  modport master (
    output icache_req, icache_addr,
    output dcache_req, dcache_addr,
    output st_valid, st_addr, st_data,
    input  st_stall,
    input  icache_proceed, dcache_proceed,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  wbuf_empty,
    input  perf_i_fills, perf_d_fills, perf_stalls
  );

endinterface

// File: rtl/mem_arbiter_wbuf_fifo.sv
// Write-through store buffer: power-of-two circular FIFO.
// Pointers wrap naturally; count carries one extra bit for full.
module wbuf_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  wbuf_entry_t din_i,
  input  logic        pop_i,
  output wbuf_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  wbuf_entry_t   mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache fill arbiter with write-through store buffer.
// Optional perf counters: define ARB_PERF_CNT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);

  arb_state_t  state_q, state_d;
  wbuf_entry_t head;
  wbuf_entry_t st_ent;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  assign st_ent = '{addr: bus.st_addr, data: bus.st_data};
  assign push   = bus.st_valid & ~full;
  assign pop    = (state_q == WRITE);

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (st_ent),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // D fills wait for an empty buffer so they never read stale data.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (full)
          state_d = WRITE;
        else if (bus.icache_req)
          state_d = GRANT_I;
        else if (bus.dcache_req && empty)
          state_d = GRANT_D;
        else if (!empty)
          state_d = WRITE;
      end
      GRANT_I: if (!bus.icache_req) state_d = IDLE;
      GRANT_D: if (!bus.dcache_req) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign bus.icache_proceed = (state_q == GRANT_I);
  assign bus.dcache_proceed = (state_q == GRANT_D);
  assign bus.mem_en         = (state_q != IDLE);
  assign bus.mem_wr         = (state_q == WRITE);
  assign bus.wbuf_empty     = empty;
  assign bus.st_stall       = bus.st_valid & full;

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      GRANT_I: bus.mem_addr = bus.icache_addr;
      GRANT_D: bus.mem_addr = bus.dcache_addr;
      WRITE: begin
        bus.mem_addr  = head.addr;
        bus.mem_wdata = head.data;
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] pi_q, pd_q, ps_q;
  logic        i_win, d_win;

  assign i_win = (state_q == IDLE) && (state_d == GRANT_I);
  assign d_win = (state_q == IDLE) && (state_d == GRANT_D);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pi_q <= '0;
      pd_q <= '0;
      ps_q <= '0;
    end else begin
      if (i_win)        pi_q <= pi_q + 16'd1;
      if (d_win)        pd_q <= pd_q + 16'd1;
      if (bus.st_stall) ps_q <= ps_q + 16'd1;
    end
  end

  assign bus.perf_i_fills = pi_q;
  assign bus.perf_d_fills = pd_q;
  assign bus.perf_stalls  = ps_q;
`else
  assign bus.perf_i_fills = '0;
  assign bus.perf_d_fills = '0;
  assign bus.perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised + directed bench for mem_arbiter against a
// queue-based bus-ownership model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int D = WBUF_DEPTH_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if bus();

  mem_arbiter #(.WBUF_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;

  // owner: 0 nobody, 1 icache, 2 dcache, 3 draining one store
  int          owner;
  st_t         q[$];
  logic [15:0] m_pi, m_pd, m_ps;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0;
    q.delete();
    m_pi = '0;
    m_pd = '0;
    m_ps = '0;
  endtask

  task automatic step(input bit rn, input bit ir,
                      input bit dr, input bit sv,
                      input logic [15:0] ia,
                      input logic [15:0] da,
                      input logic [15:0] sa,
                      input logic [15:0] sd);
    logic [15:0] e_addr, e_wd;
    logic [15:0] e_pi, e_pd, e_ps;
    bit          stall;
    int          nxt;
    @(negedge clk);
    rst_n           = rn;
    bus.icache_req  = ir;
    bus.icache_addr = ia;
    bus.dcache_req  = dr;
    bus.dcache_addr = da;
    bus.st_valid    = sv;
    bus.st_addr     = sa;
    bus.st_data     = sd;
    #1;
    stall  = sv && (q.size() == D);
    e_addr = 16'h0;
    e_wd   = 16'h0;
    if (owner == 1) e_addr = ia;
    if (owner == 2) e_addr = da;
    if (owner == 3 && q.size() > 0) begin
      e_addr = q[0].a;
      e_wd   = q[0].d;
    end
`ifdef ARB_PERF_CNT_EN
    e_pi = m_pi; e_pd = m_pd; e_ps = m_ps;
`else
    e_pi = '0; e_pd = '0; e_ps = '0;
`endif
    check("icache_proceed", 32'(bus.icache_proceed),
          32'(owner == 1));
    check("dcache_proceed", 32'(bus.dcache_proceed),
          32'(owner == 2));
    check("mem_en", 32'(bus.mem_en), 32'(owner != 0));
    check("mem_wr", 32'(bus.mem_wr), 32'(owner == 3));
    check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    check("wbuf_empty", 32'(bus.wbuf_empty),
          32'(q.size() == 0));
    check("st_stall", 32'(bus.st_stall), 32'(stall));
    check("perf_i", 32'(bus.perf_i_fills), 32'(e_pi));
    check("perf_d", 32'(bus.perf_d_fills), 32'(e_pd));
    check("perf_st", 32'(bus.perf_stalls), 32'(e_ps));
    @(posedge clk);
    cyc++;
    if (!rn) begin
      model_reset();
    end else begin
      nxt = owner;
      if (owner == 0) begin
        if (q.size() == D)              nxt = 3;
        else if (ir)                    nxt = 1;
        else if (dr && q.size() == 0)   nxt = 2;
        else if (q.size() != 0)         nxt = 3;
      end else if (owner == 1) begin
        nxt = ir ? 1 : 0;
      end else if (owner == 2) begin
        nxt = dr ? 2 : 0;
      end else begin
        nxt = 0;
      end
      if (owner == 0 && nxt == 1) m_pi = m_pi + 16'd1;
      if (owner == 0 && nxt == 2) m_pd = m_pd + 16'd1;
      if (stall) m_ps = m_ps + 16'd1;
      if (owner == 3) void'(q.pop_front());
      if (sv && !stall) q.push_back('{a: sa, d: sd});
      owner = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    bit ir, dr;
    bus.icache_req  = 0;
    bus.icache_addr = '0;
    bus.dcache_req  = 0;
    bus.dcache_addr = '0;
    bus.st_valid    = 0;
    bus.st_addr     = '0;
    bus.st_data     = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset, then icache fill at cycle 5
    step(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0);
    idle(4);
    for (int i = 0; i < 4; i++)
      step(1, 1, 0, 0, 16'h1234, 16'h0, 16'h0, 16'h0);
    idle(2);

    // simultaneous requests, icache first
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 0, 16'h0100, 16'h0200, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 0, 16'h0100, 16'h0200, 16'h0, 16'h0);
    idle(2);

    // two stores drain in order
    step(1, 0, 0, 1, 16'h0, 16'h0, 16'h0010, 16'h1111);
    step(1, 0, 0, 1, 16'h0, 16'h0, 16'h0020, 16'h2222);
    idle(5);

    // buffered stores drain before the dcache fill
    step(1, 1, 0, 0, 16'h0400, 16'h0, 16'h0, 16'h0);
    step(1, 1, 0, 1, 16'h0400, 16'h0, 16'h0030, 16'h3333);
    step(1, 1, 0, 1, 16'h0400, 16'h0, 16'h0040, 16'h4444);
    for (int i = 0; i < 7; i++)
      step(1, 0, 1, 0, 16'h0, 16'h0500, 16'h0, 16'h0);
    idle(2);

    // fill buffer during long icache fill, 5th store stalls
    step(1, 1, 0, 0, 16'h0600, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++)
      step(1, 1, 0, 1, 16'h0600, 16'h0,
           16'h0700 + 16'(i), 16'hA000 + 16'(i));
    step(1, 1, 0, 0, 16'h0600, 16'h0, 16'h0, 16'h0);
    step(1, 0, 1, 0, 16'h0, 16'h0800, 16'h0, 16'h0);
    idle(12);
    for (int i = 0; i < 6; i++)
      step(1, 0, 0, 1, 16'h0, 16'h0,
           16'h0900 + 16'(i), 16'hB000 + 16'(i));
    idle(10);

    // reset mid dcache fill with three buffered stores
    step(1, 0, 1, 0, 16'h0, 16'h0A00, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 1, 16'h0, 16'h0A00,
           16'h0B00 + 16'(i), 16'hC000 + 16'(i));
    step(0, 0, 1, 0, 16'h0, 16'h0A00, 16'h0, 16'h0);
    idle(3);

    // random traffic with sticky requests
    ir = 0;
    dr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ir = ~ir;
      if ($urandom_range(9) == 0) dr = ~dr;
      step($urandom_range(399) != 0, ir, dr,
           $urandom_range(2) == 0,
           16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
